node_upstream_merger: RTL
=========================

NODE_UPSTREAM_MERGER -- requirements
Module: node_upstream_merger

Interface
REQ-001 The block SHALL have parameter N_CHILD, default 5, giving the number of child upstream ports (one per instantiated child node).
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the payload width per message.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the output buffer depth in entries (power of two, at least 2).
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port in_valid, input, N_CHILD bits: child i offers a message.
REQ-007 Port in_data, input, N_CHILD*DATA_W bits: child i payload in slice i.
REQ-008 Port in_ready, output, N_CHILD bits: child i message accepted this cycle.
REQ-009 Port out_valid, output, 1 bit: merged message available to the parent.
REQ-010 Port out_data, output, IDX_W+DATA_W bits, where IDX_W = clog2(N_CHILD): {source child index, payload}.
REQ-011 Port out_ready, input, 1 bit: parent accepts the message.
REQ-012 Port occupancy, output, clog2(DEPTH)+1 bits: current buffer fill level.

Function
REQ-013 A transfer on either side SHALL occur only in a cycle where valid and ready are both high.
REQ-014 The arbiter SHALL grant at most one child per cycle, and only when occupancy < DEPTH, counted before the same-cycle pop.
REQ-015 The grant SHALL go to the first child with in_valid high, searching from rr_ptr upward modulo N_CHILD.
REQ-016 in_ready SHALL be one-hot or zero: in_ready[i] is high only for the granted child, combinational from in_valid, rr_ptr and occupancy.
REQ-017 After a grant to child g, rr_ptr SHALL become (g+1) mod N_CHILD; rr_ptr SHALL hold when there is no grant.
REQ-018 A granted message SHALL be written to the buffer tail as {g, in_data slice g}.
REQ-019 out_valid SHALL equal (occupancy != 0), and out_data SHALL show the head entry; both SHALL be registered state, with no combinational input-to-output path.
REQ-020 Latency: a message accepted in cycle N SHALL be visible on out_data no earlier than cycle N+1.
REQ-021 A simultaneous push and pop SHALL leave occupancy unchanged; push alone SHALL add 1; pop alone SHALL subtract 1.
REQ-022 When full: no grant; a pop in the same cycle SHALL NOT enable a push in that cycle.
REQ-023 When empty: out_valid is low, and out_ready SHALL be ignored.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.
REQ-025 Message order at the output SHALL equal grant order.
REQ-026 Head contents SHALL stay stable while out_valid is high and out_ready is low.

Reset
REQ-027 While rst_n is low: occupancy=0, out_valid=0, in_ready=0, rr_ptr=0, and buffer pointers=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered messages immediately; buffer RAM contents need not be cleared.
REQ-029 After rst_n deasserts, the first grant SHALL be possible in the first clk edge.

Structure
REQ-030 Package node_merge_pkg SHALL hold: N_CHILD, DATA_W, DEPTH defaults; IDX_W; and the packed struct msg_t {idx, payload}.
REQ-031 The buffer SHALL be a sub-module, node_merge_fifo: a synchronous FIFO of msg_t with push/pop/full/empty/count.
REQ-032 The arbiter and rr_ptr SHALL reside in node_upstream_merger.

Verification
REQ-033 Reset then idle: occupancy=0 and out_valid=0 for 10 cycles; all in_ready=0.
REQ-034 Child 3 only, payload 0x00A5, out_ready=1: in_ready[3]=1 in cycle N; out_data={3,0x00A5} in cycle N+1; rr_ptr=4.
REQ-035 All 5 valid continuously, out_ready=1, rr_ptr=0: grant order is 0,1,2,3,4,0 and output indices follow the same sequence.
REQ-036 out_ready=0, all valid: exactly 4 accepts, then in_ready=0 and occupancy=4; raise out_ready: one pop per cycle, with grants resuming the cycle after the first pop.
REQ-037 Full with pop and a pending push in the same cycle: occupancy goes to 3, and no in_ready is high that cycle.
REQ-038 rst_n pulsed low with occupancy=3: out_valid drops asynchronously; after release occupancy=0 and rr_ptr=0.

Source files
------------

// File: rtl/node_merge_pkg.sv
// Shared defaults and message type for the upstream merge path.
package node_merge_pkg;

  localparam int N_CHILD_DEF = 5;
  localparam int DATA_W_DEF  = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int IDX_W       = $clog2(N_CHILD_DEF);

  // One merged message: which child it came from, plus its payload.
  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic [DATA_W_DEF-1:0] payload;
  } msg_t;

  function automatic msg_t pack_msg(input logic [IDX_W-1:0] idx,
                                    input logic [DATA_W_DEF-1:0] payload);
    msg_t m;
    m.idx     = idx;
    m.payload = payload;
    return m;
  endfunction

endpackage

// File: rtl/node_merge_fifo.sv
// Synchronous FIFO holding merged messages; push is ignored when full
// and pop is ignored when empty.
module node_merge_fifo
  import node_merge_pkg::*;
#(
  parameter int W     = $bits(msg_t),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two; count tracks fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/node_upstream_merger.sv
// Merges N_CHILD child upstream streams into one parent stream using a
// round-robin arbiter feeding a small output FIFO. Each message is tagged
// with the index of the child it came from.
module node_upstream_merger
  import node_merge_pkg::*;
#(
  parameter int N_CHILD = N_CHILD_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_CHILD-1:0]                 in_valid,
  input  logic [N_CHILD*DATA_W-1:0]          in_data,
  output logic [N_CHILD-1:0]                 in_ready,
  output logic                               out_valid,
  output logic [$clog2(N_CHILD)+DATA_W-1:0]  out_data,
  input  logic                               out_ready,
  output logic [$clog2(DEPTH):0]             occupancy
);

  localparam int IW    = $clog2(N_CHILD);
  localparam int MSG_W = IW + DATA_W;

  logic [N_CHILD-1:0][DATA_W-1:0] child_data;
  logic [IW-1:0]                  rr_ptr;
  logic [IW-1:0]                  gnt_idx;
  logic [IW:0]                    cand;
  logic                           found;
  logic                           push, pop;
  logic                           fifo_full, fifo_empty;

  for (genvar i = 0; i < N_CHILD; i++) begin : g_slice
    assign child_data[i] = in_data[i*DATA_W +: DATA_W];
  end

  // Pick the first valid child at or after rr_ptr, wrapping modulo N_CHILD.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_CHILD; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_CHILD)) cand = cand - (IW+1)'(N_CHILD);
      if (!found && in_valid[cand[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  // Fullness is judged before any same-cycle pop, so a pop never opens a slot
  // for a push in the same cycle. rst_n gates the grant so in_ready stays low
  // throughout reset.
  assign push = found & ~fifo_full & rst_n;
  assign pop  = out_ready & ~fifo_empty;

  // One-hot ready for the granted child only.
  always_comb begin
    in_ready = '0;
    if (push) in_ready[gnt_idx] = 1'b1;
  end

  // Advance the round-robin pointer past the winner; hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gnt_idx == IW'(N_CHILD-1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  node_merge_fifo #(
    .W     (MSG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({gnt_idx, child_data[gnt_idx]}),
    .pop   (pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign out_valid = ~fifo_empty;

endmodule
